// File: rtl/fp_normalize_pipe.sv
// rtl/fp_normalize_pipe.sv - two-stage FP normalize/round/classify pipeline; rounding enabled by FP_NORM_ROUND_EN
module fp_normalize_pipe #(
    parameter int   WIDTH     = 8,
    localparam int  WIDTH_LOG = $clog2(WIDTH),
    parameter int   FRAC_POS  = WIDTH - 2,
    parameter int   MANT_W    = 4,
    parameter int   EXP_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic [WIDTH-1:0]     Sum_mag,
    input  logic [WIDTH_LOG-1:0] msb_pos,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [EXP_W-1:0]     out_exp,
    output logic [MANT_W-1:0]    out_mant,
    output logic                 out_zero,
    output logic                 out_of,
    output logic                 out_uf
);

    // Exponent arithmetic width: two extra bits hold the sign and the carry.
    localparam int EW   = EXP_W + 2;
    // Guard bit sits just below the kept mantissa bits.
    localparam int GPOS = WIDTH - 2 - MANT_W;
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic                 s1_valid;
    logic                 s1_sign;
    logic                 s1_zero;
    logic [WIDTH-1:0]     s1_sh;
    logic [EW-1:0]        s1_e;
    logic                 s2_valid;

    logic                 s1_load;
    logic                 s2_load;

    logic [WIDTH_LOG-1:0] sh_amt;
    logic [WIDTH-1:0]     sh_c;
    logic [EW-1:0]        e_c;
    logic                 zero_c;

    logic [MANT_W-1:0]    mant_c;
    logic [MANT_W-1:0]    mant_r;
    logic                 carry;
    logic [EW-1:0]        e_r;
    logic [EXP_W-1:0]     r_exp;
    logic [MANT_W-1:0]    r_mant;
    logic                 r_zero;
    logic                 r_of;
    logic                 r_uf;
    logic                 unused_bits;

    // A stage can load when empty or when its content leaves this cycle.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    // Stage 1 datapath: move the leading 1 to the top bit and rebias the exponent.
    always_comb begin
        zero_c = (Sum_mag == '0);
        sh_amt = WIDTH_LOG'(WIDTH - 1) - msb_pos;
        sh_c   = Sum_mag << sh_amt;
        e_c    = EW'(in_exp) + EW'(msb_pos) - EW'(FRAC_POS);
    end

    // Stage 2 datapath: round (optionally), then classify zero/underflow/overflow/normal.
    always_comb begin
        mant_c = s1_sh[WIDTH-2 -: MANT_W];
`ifdef FP_NORM_ROUND_EN
        begin
            logic guard;
            logic sticky;
            logic inc;
            guard  = s1_sh[GPOS];
            sticky = |(s1_sh & ((WIDTH'(1) << GPOS) - WIDTH'(1)));
            inc    = guard && (sticky || mant_c[0]);
            {carry, mant_r} = {1'b0, mant_c} + (MANT_W + 1)'(inc);
        end
        unused_bits = s1_sh[WIDTH-1];
`else
        carry       = 1'b0;
        mant_r      = mant_c;
        unused_bits = ^{s1_sh[WIDTH-1], s1_sh[GPOS:0]};
`endif
        e_r    = s1_e + EW'(carry);
        r_exp  = '0;
        r_mant = '0;
        r_zero = 1'b0;
        r_of   = 1'b0;
        r_uf   = 1'b0;
        if (s1_zero) begin
            r_zero = 1'b1;
        end else if (e_r[EW-1] || (e_r == '0)) begin
            r_uf   = 1'b1;
            r_zero = 1'b1;
        end else if (e_r >= EXP_MAX) begin
            r_of   = 1'b1;
            r_exp  = '1;
        end else begin
            r_exp  = e_r[EXP_W-1:0];
            r_mant = mant_r;
        end
    end

    // Stage 1 register: capture a beat whenever the stage can load.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_sh    <= '0;
            s1_e     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_zero <= zero_c;
                s1_sh   <= sh_c;
                s1_e    <= e_c;
            end
        end
    end

    // Stage 2 register: output fields only change when the consumer is not stalling.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_mant <= '0;
            out_zero <= 1'b0;
            out_of   <= 1'b0;
            out_uf   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign <= s1_sign;
                out_exp  <= r_exp;
                out_mant <= r_mant;
                out_zero <= r_zero;
                out_of   <= r_of;
                out_uf   <= r_uf;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb/tb_fp_normalize_pipe.sv - scoreboard bench for fp_normalize_pipe
module tb_fp_normalize_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sign = 1'b0;
    logic [4:0] in_exp = '0;
    logic [7:0] Sum_mag = '0;
    logic [2:0] msb_pos = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_sign;
    logic [4:0] out_exp;
    logic [3:0] out_mant;
    logic       out_zero;
    logic       out_of;
    logic       out_uf;

    fp_normalize_pipe #(.WIDTH(8), .FRAC_POS(6), .MANT_W(4), .EXP_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .Sum_mag(Sum_mag), .msb_pos(msb_pos),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
        .out_zero(out_zero), .out_of(out_of), .out_uf(out_uf)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_push = 0;
    int          n_pop = 0;
    int          n_drop = 0;
    logic [12:0] sb[$];
    logic [12:0] cur_exp;
    logic        hold = 1'b0;
    logic [13:0] snap;
    logic        s_ov;
    logic        s_ir;
    logic [12:0] s_pack;
    logic        acc;
    logic [12:0] e2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [12:0] mk(input logic s, input int ex, input int mt,
                                       input logic z, input logic o, input logic u);
        return {s, 5'(ex), 4'(mt), z, o, u};
    endfunction

    function automatic logic [2:0] lead(input logic [7:0] mag);
        logic [2:0] p = '0;
        for (int i = 0; i < 8; i++) if (mag[i]) p = 3'(i);
        return p;
    endfunction

    // Reference: value = mag * 2^(exp-6); hidden bit at 2^0 of normalized value.
    function automatic logic [12:0] model(input logic s, input logic [4:0] ex, input logic [7:0] mag);
        int p, norm, frac, mt, rem, e;
        if (mag == 0) return mk(s, 0, 0, 1'b1, 1'b0, 1'b0);
        p    = int'(lead(mag));
        norm = (int'(mag) << (7 - p)) & 255;
        frac = norm & 127;
        mt   = frac / 8;
        rem  = frac % 8;
        e    = int'(ex) + p - 6;
`ifdef FP_NORM_ROUND_EN
        if (rem > 4 || (rem == 4 && (mt % 2) == 1)) mt = mt + 1;
        if (mt == 16) begin
            mt = 0;
            e  = e + 1;
        end
`else
        rem = 0;
`endif
        if (e <= 0)  return mk(s, 0, 0, 1'b1, 1'b0, 1'b1);
        if (e >= 31) return mk(s, 31, 0, 1'b0, 1'b1, 1'b0);
        return mk(s, e, mt, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic step(output logic a);
        @(negedge clk);
        s_ov   = out_valid;
        s_ir   = in_ready;
        s_pack = {out_sign, out_exp, out_mant, out_zero, out_of, out_uf};
        a      = in_valid && in_ready && !rst;
        if (rst) begin
            n_drop += sb.size();
            sb.delete();
            hold = 1'b0;
        end else begin
            if (hold) check("hold_stable", 32'({out_valid, s_pack}), 32'(snap));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("out_unexpected", 32'(out_valid), 32'(0));
                else begin
                    check("result", 32'(s_pack), 32'(sb.pop_front()));
                    n_pop++;
                end
            end
            hold = out_valid && !out_ready;
            snap = {out_valid, s_pack};
            if (a) begin
                sb.push_back(cur_exp);
                n_push++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [4:0] ex, input logic [7:0] mag,
                        input logic [2:0] mp, input logic [12:0] expv);
        logic a;
        int   tries = 0;
        in_sign = s; in_exp = ex; Sum_mag = mag; msb_pos = mp; cur_exp = expv; in_valid = 1'b1;
        do begin
            step(a);
            tries++;
            if (!a && tries >= 2) out_ready = 1'b1;
        end while (!a && tries < 50);
        if (!a) check("send_timeout", 32'(a), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic       s  = 1'($urandom_range(0, 1));
        logic [4:0] ex = 5'($urandom_range(0, 31));
        logic [7:0] mg = 8'($urandom_range(0, 255));
        logic [2:0] mp = (mg == 0) ? 3'($urandom_range(0, 7)) : lead(mg);
        send(s, ex, mg, mp, model(s, ex, mg));
    endtask

    initial begin
        step(acc);
        step(acc);
        rst = 1'b0;
        step(acc);
        check("reset_out_valid", 32'(s_ov), 32'(0));
        check("reset_in_ready", 32'(s_ir), 32'(1));
        check("reset_outputs", 32'(s_pack), 32'(0));

        send(1'b0, 5'd15, 8'b0100_0000, 3'd6, mk(0, 15, 0, 0, 0, 0));
        step(acc);
        check("latency_c1", 32'(s_ov), 32'(0));
        step(acc);
        check("latency_c2", 32'(s_ov), 32'(1));

        send(1'b0, 5'd15, 8'b1000_0000, 3'd7, mk(0, 16, 0, 0, 0, 0));
`ifdef FP_NORM_ROUND_EN
        e2 = mk(0, 16, 0, 0, 0, 0);
`else
        e2 = mk(0, 15, 15, 0, 0, 0);
`endif
        send(1'b0, 5'd15, 8'b0111_1110, 3'd6, e2);
        send(1'b0, 5'd15, 8'b0100_0010, 3'd6, mk(0, 15, 0, 0, 0, 0));
        send(1'b1, 5'd9,  8'b0000_0000, 3'd3, mk(1, 0, 0, 1, 0, 0));
        send(1'b0, 5'd5,  8'b0000_0001, 3'd0, mk(0, 0, 0, 1, 0, 1));
        send(1'b1, 5'd30, 8'b1000_0000, 3'd7, mk(1, 31, 0, 0, 1, 0));
        send(1'b0, 5'd12, 8'b0101_0101, 3'd6, model(1'b0, 5'd12, 8'b0101_0101));
        repeat (3) step(acc);

        out_ready = 1'b0;
        send(1'b0, 5'd10, 8'b0100_0000, 3'd6, model(1'b0, 5'd10, 8'b0100_0000));
        send(1'b1, 5'd11, 8'b0011_0011, 3'd5, model(1'b1, 5'd11, 8'b0011_0011));
        in_sign = 1'b0; in_exp = 5'd20; Sum_mag = 8'b1110_0001; msb_pos = 3'd7; in_valid = 1'b1;
        cur_exp = model(1'b0, 5'd20, 8'b1110_0001);
        step(acc);
        check("stall_in_ready_a", 32'(s_ir), 32'(0));
        step(acc);
        check("stall_in_ready_b", 32'(s_ir), 32'(0));
        out_ready = 1'b1;
        send(1'b0, 5'd20, 8'b1110_0001, 3'd7, model(1'b0, 5'd20, 8'b1110_0001));
        send(1'b1, 5'd3,  8'b0000_1111, 3'd3, model(1'b1, 5'd3, 8'b0000_1111));
        repeat (4) step(acc);

        repeat (40) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send_rand();
            if ($urandom_range(0, 3) == 0) step(acc);
        end
        out_ready = 1'b1;
        repeat (5) step(acc);

        out_ready = 1'b0;
        send_rand();
        send_rand();
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        step(acc);
        check("rst_mid_out_valid", 32'(s_ov), 32'(0));
        check("rst_mid_in_ready", 32'(s_ir), 32'(1));
        check("rst_mid_outputs", 32'(s_pack), 32'(0));
        out_ready = 1'b1;
        repeat (5) step(acc);
        send_rand();
        send_rand();
        repeat (5) step(acc);

        check("sb_empty", 32'(sb.size()), 32'(0));
        check("out_count", 32'(n_pop), 32'(n_push - n_drop));
        check("dropped", 32'(n_drop), 32'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_normalize_pipe.md
Name: fp_normalize_pipe

Overview:
- Floating-point normalization stage directly downstream of the leading_1_in_mantisa priority encoder.
- Consumes the unnormalized magnitude Sum_mag, the encoder's msb_pos and a pre-normalization exponent.
- Shifts the leading 1 into the hidden-bit position, adjusts the exponent, rounds and flags overflow/underflow.
- 2-stage valid/ready pipeline; full throughput.

Parameters:
- WIDTH, 8: Sum_mag width; must match the encoder.
- WIDTH_LOG, $clog2(WIDTH): msb_pos width (localparam).
- FRAC_POS, WIDTH-2: bit position of Sum_mag that weighs 1.0.
- MANT_W, 4: output mantissa width, hidden bit excluded; MANT_W <= WIDTH-2.
- EXP_W, 5: biased exponent width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage accepts a beat
- in_sign  in  1  sign
- in_exp  in  EXP_W  biased exponent of the Sum_mag fixed-point value
- Sum_mag  in  WIDTH  unnormalized magnitude
- msb_pos  in  WIDTH_LOG  leading-1 position from the encoder
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_sign  out  1  sign
- out_exp  out  EXP_W  normalized biased exponent
- out_mant  out  MANT_W  fraction bits, hidden bit dropped
- out_zero  out  1  result is zero (exact zero or flushed)
- out_of  out  1  overflow, result forced to infinity
- out_uf  out  1  underflow, result flushed to zero

Behaviour:
- Reset: one clock, synchronous, active-high. rst=1 at a clk edge clears both stage valids. All outputs read 0; in_ready=1 the cycle after reset. Reset mid-operation discards in-flight beats without emitting them.
- Handshake: a transfer occurs when valid&&ready at a clk edge.
  - Each stage loads when it is empty or its content is consumed in the same cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready); combinational only on out_ready and internal valids.
  - Output fields stay stable while out_valid && !out_ready.
- Latency: 2 cycles from input transfer to out_valid with no backpressure; one result per cycle sustained.
- Stage 1 (shift/exp):
  - zero = (Sum_mag==0); msb_pos is ignored when zero=1.
  - sh = Sum_mag << (WIDTH-1-msb_pos), which puts the leading 1 at bit WIDTH-1.
  - e = in_exp + msb_pos - FRAC_POS, evaluated signed at EXP_W+2 bits.
- Stage 2 (round/flags):
  - mant = sh[WIDTH-2 -: MANT_W]; guard = the next bit below; sticky = OR of all remaining lower bits.
  - Round nearest-even: increment when guard && (sticky || mant[0]).
  - Mantissa carry-out: mant=0, e=e+1.
- Output classification, in priority order:
  1. zero: out_zero=1, exp=0, mant=0, no flags.
  2. e <= 0: out_uf=1, out_zero=1, exp=0, mant=0. No denormals.
  3. e >= 2^EXP_W-1 after rounding: out_of=1, exp all-ones, mant=0.
  4. Otherwise: normal result.
- out_sign passes through unchanged, including for zero and infinity results.
- msb_pos is trusted to match the encoder's contract. Inconsistent msb_pos gives undefined mantissa but never corrupts the handshake.

Optional Feature:
- Macro FP_NORM_ROUND_EN.
- Defined: nearest-even rounding as specified above.
- Undefined: truncation. guard/sticky logic is removed; rounding carry never occurs; overflow is checked on the unrounded e.

Test Plan (WIDTH=8, MANT_W=4, EXP_W=5, FRAC_POS=6, out_ready=1 unless stated):
1. Sum_mag=8'b0100_0000, msb_pos=6, in_exp=15 -> 2 cycles later out_valid=1, exp=15, mant=4'b0000, no flags. Repeat with 8'b1000_0000, msb_pos=7 -> exp=16.
2. Sum_mag=8'b0111_1110, msb_pos=6, exp=15 -> tie rounds up with carry -> exp=16, mant=0000. Without FP_NORM_ROUND_EN -> exp=15, mant=1111.
3. Sum_mag=8'b0100_0010, msb_pos=6, exp=15 -> tie to even -> exp=15, mant=0000. Sum_mag=0, in_sign=1 -> out_zero=1, sign=1, flags 0.
4. Sum_mag=8'b0000_0001, msb_pos=0, exp=5 -> e=-1 -> out_uf=1, out_zero=1. Sum_mag=8'b1000_0000, msb_pos=7, exp=30 -> out_of=1, exp=31, mant=0.
5. Stream 4 beats back-to-back, hold out_ready=0 for 3 cycles -> in_ready drops after 2 beats are buffered; output held stable; all 4 results emitted in order, none lost or duplicated.
6. Assert rst for one cycle with 2 beats in flight -> out_valid=0 and all outputs 0 next cycle, in_ready=1; dropped beats never appear.
